// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation encodings and FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier; the first iteration is folded into the start
// cycle so the product is ready WIDTH cycles after start.
module alu_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplr_in,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             running;

  logic [WIDTH-1:0] step_mcand;
  logic [WIDTH-1:0] step_mplr;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH:0]   step_sum;

  // On start the iteration operates on the fresh operands with a cleared accumulator.
  always_comb begin
    step_mcand = start ? mcand_in : mcand;
    step_mplr  = start ? mplr_in  : mplr;
    step_acc   = start ? '0       : acc;
    step_sum   = {1'b0, step_acc} +
                 (step_mplr[0] ? {1'b0, step_mcand} : {(WIDTH+1){1'b0}});
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      mcand   <= mcand_in;
      acc     <= step_sum[WIDTH:1];
      mplr    <= {step_sum[0], step_mplr[WIDTH-1:1]};
      cnt     <= CW'(1);
      running <= 1'b1;
      done    <= 1'b0;
    end else if (running) begin
      acc  <= step_sum[WIDTH:1];
      mplr <= {step_sum[0], step_mplr[WIDTH-1:1]};
      cnt  <= cnt + CW'(1);
      if (cnt == LAST) begin
        running <= 1'b0;
        done    <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign product_hi = acc;
  assign product_lo = mplr;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU behind a valid/ready handshake.
// Define ALU_MUL_EN to build the multi-cycle multiplier for op 7.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  alu_state_t state_q;
  alu_state_t state_d;
  logic       load_single;

  logic [SHW-1:0]   sh_amt;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;
  logic [WIDTH-1:0] sc_result;
  logic             sc_carry;
  logic             sc_ovf;
  logic             sc_err;

`ifdef ALU_MUL_EN
  logic             load_mul;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk       (clk),
    .reset_L   (reset_L),
    .start     (mul_start),
    .mcand_in  (a),
    .mplr_in   (b),
    .done      (mul_done),
    .product_hi(mul_hi),
    .product_lo(mul_lo)
  );
`endif

  // Widened forms expose carry/borrow and the last bit shifted out in one extra bit.
  assign sh_amt = b[SHW-1:0];
  assign add_w  = {1'b0, a} + {1'b0, b};
  assign sub_w  = {1'b0, a} - {1'b0, b};
  assign shl_w  = {1'b0, a} << sh_amt;
  assign shr_w  = {a, 1'b0} >> sh_amt;

  always_comb begin
    sc_result = '0;
    sc_carry  = 1'b0;
    sc_ovf    = 1'b0;
    sc_err    = 1'b0;
    case (op)
      OP_ADD: begin
        sc_result = add_w[WIDTH-1:0];
        sc_carry  = add_w[WIDTH];
        sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = sub_w[WIDTH-1:0];
        sc_carry  = sub_w[WIDTH];
        sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: sc_result = a & b;
      OP_OR:  sc_result = a | b;
      OP_XOR: sc_result = a ^ b;
      OP_SHL: begin
        sc_result = shl_w[WIDTH-1:0];
        sc_carry  = shl_w[WIDTH];
      end
      OP_SHR: begin
        sc_result = shr_w[WIDTH:1];
        sc_carry  = shr_w[0];
      end
      default: begin
`ifndef ALU_MUL_EN
        sc_err = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A retiring result and a new request may share the same edge.
  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    load_single = 1'b0;
`ifdef ALU_MUL_EN
    load_mul    = 1'b0;
    mul_start   = 1'b0;
`endif
    case (state_q)
      IDLE: in_ready = 1'b1;
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
`ifdef ALU_MUL_EN
        if (mul_done) begin
          state_d  = DONE;
          load_mul = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (in_valid && in_ready) begin
`ifdef ALU_MUL_EN
      if (op == OP_MUL) begin
        state_d   = BUSY;
        mul_start = 1'b1;
      end else begin
        state_d     = DONE;
        load_single = 1'b1;
      end
`else
      state_d     = DONE;
      load_single = 1'b1;
`endif
    end
  end

  // Result registers only load on completion, so they hold under backpressure.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      result    <= '0;
      result_hi <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else if (load_single) begin
      result    <= sc_result;
      result_hi <= '0;
      carry     <= sc_carry;
      zero      <= (sc_result == '0);
      ovf       <= sc_ovf;
      err       <= sc_err;
    end
`ifdef ALU_MUL_EN
    else if (load_mul) begin
      result    <= mul_lo;
      result_hi <= mul_hi;
      carry     <= 1'b0;
      zero      <= ({mul_hi, mul_lo} == '0);
      ovf       <= 1'b0;
      err       <= 1'b0;
    end
`endif
  end

  assign out_valid = (state_q == DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=4): directed vectors with literal
// expectations plus an arithmetic reference model checked every cycle.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic [3:0] res;
    logic [3:0] hi;
    logic       c;
    logic       z;
    logic       v;
    logic       e;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    int         ready_cyc;
  } txn_t;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] op = 3'd0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] result;
  logic [3:0] result_hi;
  logic       carry;
  logic       zero;
  logic       ovf;
  logic       err;

  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  txn_t q[$];

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .result_hi(result_hi),
    .carry    (carry),
    .zero     (zero),
    .ovf      (ovf),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Reference model straight from the operation table, using plain integers.
  function automatic exp_t model(input logic [2:0] m_op, input logic [3:0] m_a, input logic [3:0] m_b);
    exp_t r;
    int ia, ib, sa, sb, s, sh, p;
    ia = int'(m_a);
    ib = int'(m_b);
    sa = (ia >= 8) ? ia - 16 : ia;
    sb = (ib >= 8) ? ib - 16 : ib;
    sh = ib % 4;
    p  = 0;
    r  = '0;
    case (m_op)
      3'd0: begin
        s = ia + ib;
        r.res = 4'(s % 16);
        r.c = (s >= 16);
        r.v = ((sa + sb) > 7) || ((sa + sb) < -8);
      end
      3'd1: begin
        s = ia - ib;
        r.res = 4'((s + 16) % 16);
        r.c = (ia < ib);
        r.v = ((sa - sb) > 7) || ((sa - sb) < -8);
      end
      3'd2: r.res = m_a & m_b;
      3'd3: r.res = m_a | m_b;
      3'd4: r.res = m_a ^ m_b;
      3'd5: begin
        r.res = 4'((ia << sh) % 16);
        r.c = (sh == 0) ? 1'b0 : 1'(((ia >> (4 - sh)) & 1));
      end
      3'd6: begin
        r.res = 4'(ia >> sh);
        r.c = (sh == 0) ? 1'b0 : 1'(((ia >> (sh - 1)) & 1));
      end
      default: begin
`ifdef ALU_MUL_EN
        p = ia * ib;
        r.res = 4'(p % 16);
        r.hi = 4'(p / 16);
`else
        r.e = 1'b1;
`endif
      end
    endcase
    r.z = (r.res == 4'd0) && (r.hi == 4'd0);
    return r;
  endfunction

  always @(negedge clk) begin : scoreboard
    bit   front_ok;
    bit   exp_ready;
    int   lat;
    exp_t e;
    txn_t t;
    #3;
    if (!reset_L) begin
      q.delete();
      check_output("rst_out_valid", out_valid, 0);
      check_output("rst_result", result, 0);
      check_output("rst_result_hi", result_hi, 0);
      check_output("rst_flags", {carry, zero, ovf, err}, 0);
    end else begin
      front_ok  = (q.size() > 0) && (cyc >= q[0].ready_cyc);
      exp_ready = (q.size() == 0) || (front_ok && out_ready);
      check_output("sb_out_valid", out_valid, front_ok);
      check_output("sb_in_ready", in_ready, exp_ready);
      if (front_ok && out_valid) begin
        e = model(q[0].op, q[0].a, q[0].b);
        check_output("sb_result", result, e.res);
        check_output("sb_result_hi", result_hi, e.hi);
        check_output("sb_carry", carry, e.c);
        check_output("sb_zero", zero, e.z);
        check_output("sb_ovf", ovf, e.v);
        check_output("sb_err", err, e.e);
      end
      if (front_ok && out_ready) begin
        void'(q.pop_front());
      end
      if (in_valid && exp_ready) begin
`ifdef ALU_MUL_EN
        lat = (op == 3'd7) ? WIDTH : 0;
`else
        lat = 0;
`endif
        t.op = op;
        t.a = a;
        t.b = b;
        t.ready_cyc = cyc + 1 + lat;
        q.push_back(t);
      end
    end
  end

  // Presents one request, scrambles the operands after acceptance, and counts
  // cycles from the handshake cycle to the first cycle with out_valid high.
  task automatic apply_stimulus(input logic [2:0] op_i, input logic [3:0] a_i, input logic [3:0] b_i,
                                input bit busy_chk, output int lat);
    int guard;
    @(negedge clk);
    op = op_i;
    a = a_i;
    b = b_i;
    in_valid = 1'b1;
    guard = 0;
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) check_output("accept_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);
    #2;
    lat = 1;
    while (!out_valid && lat < 50) begin
      if (busy_chk) check_output("busy_in_ready", in_ready, 0);
      @(negedge clk);
      #2;
      lat++;
    end
    check_output("out_valid_seen", out_valid, 1);
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    int   lat;
    int   guard;
    bit   acc_last;
    vec_t burst [8];

    burst = '{'{OP_XOR, 4'h5, 4'hF}, '{OP_OR, 4'h8, 4'h1}, '{OP_AND, 4'h6, 4'h3},
              '{OP_SHR, 4'h9, 4'h3}, '{OP_SHL, 4'h5, 4'h0}, '{OP_SHR, 4'h8, 4'h0},
              '{OP_SUB, 4'h5, 4'h5}, '{OP_ADD, 4'h8, 4'h8}};

    repeat (2) @(negedge clk);
    #1;
    check_output("reset_out_valid", out_valid, 0);
    check_output("reset_result", result, 0);
    reset_L = 1'b1;
    #1;
    check_output("reset_in_ready", in_ready, 1);

    apply_stimulus(OP_ADD, 4'h1, 4'hE, 1'b0, lat);
    check_output("add1_latency", lat, 1);
    check_output("add1_result", result, 4'hF);
    check_output("add1_flags", {carry, zero, ovf}, 3'b000);

    apply_stimulus(OP_ADD, 4'hF, 4'hF, 1'b0, lat);
    check_output("add2_result", result, 4'hE);
    check_output("add2_carry", carry, 1);
    check_output("add2_ovf", ovf, 0);

    apply_stimulus(OP_SUB, 4'h0, 4'h1, 1'b0, lat);
    check_output("sub1_result", result, 4'hF);
    check_output("sub1_borrow", carry, 1);

    apply_stimulus(OP_SUB, 4'h7, 4'hF, 1'b0, lat);
    check_output("sub2_result", result, 4'h8);
    check_output("sub2_ovf", ovf, 1);

    apply_stimulus(OP_SHL, 4'hE, 4'h1, 1'b0, lat);
    check_output("shl_result", result, 4'hC);
    check_output("shl_carry", carry, 1);

`ifdef ALU_MUL_EN
    apply_stimulus(OP_MUL, 4'hF, 4'hF, 1'b1, lat);
    check_output("mul_latency", lat, 5);
    check_output("mul_result_hi", result_hi, 4'hE);
    check_output("mul_result", result, 4'h1);
    check_output("mul_err", err, 0);
`else
    apply_stimulus(OP_MUL, 4'hF, 4'hF, 1'b0, lat);
    check_output("op7_latency", lat, 1);
    check_output("op7_err", err, 1);
    check_output("op7_zero", zero, 1);
    check_output("op7_result", result, 4'h0);
    check_output("op7_result_hi", result_hi, 4'h0);
`endif

    // Back-to-back single-cycle ops with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {op, a, b} = burst[i];
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Backpressure: ADD held for three cycles, then AND accepted on retirement.
    out_ready = 1'b0;
    op = OP_ADD;
    a = 4'h2;
    b = 4'h3;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        op = OP_AND;
        a = 4'hC;
        b = 4'hA;
      end
      #1;
      check_output("bp_hold_valid", out_valid, 1);
      check_output("bp_hold_result", result, 4'h5);
      check_output("bp_hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check_output("bp_release_in_ready", in_ready, 1);
    check_output("bp_release_result", result, 4'h5);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_output("bp_and_valid", out_valid, 1);
    check_output("bp_and_result", result, 4'h8);

    // Reset while an operation is in flight.
`ifdef ALU_MUL_EN
    @(negedge clk);
    op = OP_MUL;
    a = 4'hF;
    b = 4'hF;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
`else
    @(negedge clk);
    out_ready = 1'b0;
    op = OP_ADD;
    a = 4'h2;
    b = 4'h3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
`endif
    reset_L = 1'b0;
    #1;
    check_output("midrst_out_valid", out_valid, 0);
    check_output("midrst_result", result, 0);
    check_output("midrst_result_hi", result_hi, 0);
    check_output("midrst_flags", {carry, zero, ovf, err}, 0);
    @(negedge clk);
    out_ready = 1'b1;
    reset_L = 1'b1;
    apply_stimulus(OP_ADD, 4'h1, 4'h1, 1'b0, lat);
    check_output("postrst_latency", lat, 1);
    check_output("postrst_result", result, 4'h2);
    check_output("postrst_carry", carry, 0);

    // Mixed traffic with random backpressure; the scoreboard does the checking.
    acc_last = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (acc_last || !in_valid) begin
        op = 3'($urandom);
        a = 4'($urandom);
        b = 4'($urandom);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc_last = in_valid && in_ready;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (q.size() > 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    check_output("drain_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the legacy 4-bit combinational ALU. It executes one operation per accepted request over a valid/ready handshake. Single-cycle logic and arithmetic ops complete with one cycle of latency. Multiply is a multi-cycle shift-add sequence. The block sits between operand-issue logic and a result consumer that may apply backpressure.

## Interface
- WIDTH, 4: operand and result width. Must be ≥ 2.
- SHW, $clog2(WIDTH): shift-amount width, derived. Do not override.

- clk  in  1: single clock; all state updates on the rising edge.
- reset_L  in  1: asynchronous, active-low reset.
- in_valid  in  1: request valid.
- in_ready  out  1: block can accept a request.
- op  in  3: operation select.
- a  in  WIDTH: operand A.
- b  in  WIDTH: operand B; only b[SHW-1:0] is used for shifts.
- out_valid  out  1: result valid.
- out_ready  in  1: consumer accepts the result.
- result  out  WIDTH: result; low half for MUL.
- result_hi  out  WIDTH: high half of the MUL product; 0 for all other ops.
- carry  out  1: carry/borrow/shifted-out bit.
- zero  out  1: full result == 0 (for MUL, the 2·WIDTH product).
- ovf  out  1: signed overflow, ADD/SUB only; 0 otherwise.
- err  out  1: unsupported op.

## Operation
- Op encoding:
  - 0 ADD: carry = carry out.
  - 1 SUB: a−b; carry = 1 on borrow (a<b unsigned).
  - 2 AND, 3 OR, 4 XOR: carry = 0.
  - 5 SHL, 6 SHR: logical shift; carry = last bit shifted out; shift by 0 gives carry = 0.
  - 7 MUL: unsigned.
- A request is accepted on an edge where in_valid & in_ready.
- FSM states:
  - IDLE → DONE on accept of ops 0–6.
  - IDLE → BUSY on accept of MUL.
  - BUSY: one shift-add iteration per cycle for WIDTH cycles; after the last iteration → DONE.
  - DONE: out_valid = 1. On out_ready: go → IDLE, or → DONE/BUSY directly if a new request is accepted on the same edge.
- in_ready = (state==IDLE) | (state==DONE & out_ready). in_ready is 0 in BUSY.
- While out_valid & !out_ready, all outputs hold stable.
- Operands are captured at accept; a and b may change afterwards.
- Reset (any state, including mid-MUL) → IDLE. Reset values:
  - out_valid = 0.
  - result, result_hi, carry, zero, ovf, err = 0.
  - in_ready = 1 once reset_L deasserts.
  - A partially computed product is discarded.

## Timing
- Ops 0–6: accept at edge N → out_valid high after edge N+1. Latency 1.
- MUL: accept at edge N → BUSY during cycles N+1..N+WIDTH → out_valid after edge N+WIDTH+1. Latency WIDTH+1.
- Back-to-back throughput: one single-cycle op per clock while out_ready is held high.
- in_ready is combinational from state and out_ready. There is no other combinational input→output path.

## Configuration
- ALU_MUL_EN defined: MUL implemented as above.
- ALU_MUL_EN undefined: the multiplier is not built and BUSY is unreachable. Op 7 completes in 1 cycle with:
  - result = 0, result_hi = 0
  - carry = 0, ovf = 0
  - zero = 1, err = 1
- err is always 0 when ALU_MUL_EN is defined.

## Structure
- Shared package alu_pkg holds:
  - op encoding constants (OP_ADD..OP_MUL)
  - FSM state typedef (IDLE, BUSY, DONE)
- Sub-module alu_mul_seq holds the shift-add multiplier:
  - start/done
  - WIDTH-bit multiplicand, multiplier, accumulator
  - iteration counter
- alu_mul_seq is instantiated only under ALU_MUL_EN.

## Test plan
All scenarios use WIDTH=4.
- ADD a=1, b=E → result F, carry 0, zero 0, ovf 0, one cycle after accept.
- ADD a=F, b=F → result E, carry 1, ovf 0.
- SUB a=0, b=1 → result F, carry 1 (borrow).
- SUB a=7, b=F → result 8, ovf 1.
- SHL a=E, b=1 → result C, carry 1.
- MUL a=F, b=F (ALU_MUL_EN) → result_hi E, result 1, out_valid exactly 5 cycles after accept, in_ready 0 during BUSY.
- Without ALU_MUL_EN, op 7 → err 1, zero 1, result 0.
- Backpressure: ADD a=2, b=3 with out_ready low for 3 cycles → result 5 held stable, in_ready 0. On out_ready with in_valid high (AND a=C, b=A): first result retires, AND accepted the same edge, result 8 one cycle later.
- Reset mid-MUL: assert reset_L low during BUSY → out_valid 0 and all outputs 0 immediately. After release, ADD a=1, b=1 → result 2, carry 0.
